// File: rtl/sram_1r1w_model.sv
// Behavioural two-port SRAM: one masked synchronous write port and one pipelined synchronous
// read port, with a selectable same-address collision policy and a saturating collision counter.
module sram_1r1w_model #(
  parameter int DATA_WIDTH   = 8,
  parameter int ADDR_WIDTH   = 4,
  parameter int RAM_DEPTH    = 1 << ADDR_WIDTH,
  parameter int NUM_WMASK    = 1,
  parameter int READ_LATENCY = 1,
  parameter int WRITE_MODE   = 0
) (
  input  logic                  clk,
  input  logic                  rstb,
  input  logic                  W_CSb,
  input  logic [ADDR_WIDTH-1:0] W_ADDR,
  input  logic [DATA_WIDTH-1:0] W_DATA,
  input  logic [NUM_WMASK-1:0]  W_MASK,
  input  logic                  R_CSb,
  input  logic [ADDR_WIDTH-1:0] R_ADDR,
  output logic [DATA_WIDTH-1:0] R_DATA,
  output logic                  R_VALID,
  output logic                  R_ERR,
  output logic [15:0]           COLLISIONS
);

  localparam int LW = DATA_WIDTH / NUM_WMASK;
  localparam logic [ADDR_WIDTH:0] DEPTH_L = (ADDR_WIDTH + 1)'(RAM_DEPTH);

  if (READ_LATENCY < 1 || READ_LATENCY > 4) begin : g_bad_latency
    $error("sram_1r1w_model: READ_LATENCY %0d outside 1..4", READ_LATENCY);
  end
  if (DATA_WIDTH % NUM_WMASK != 0) begin : g_bad_mask
    $error("sram_1r1w_model: DATA_WIDTH %0d not divisible by NUM_WMASK %0d", DATA_WIDTH, NUM_WMASK);
  end
  if (RAM_DEPTH > (1 << ADDR_WIDTH)) begin : g_bad_depth
    $error("sram_1r1w_model: RAM_DEPTH %0d exceeds address space", RAM_DEPTH);
  end

  logic [DATA_WIDTH-1:0] r_mem [RAM_DEPTH];

  logic                    w_wr_ok;
  logic                    w_rd_ok;
  logic                    w_collide;
  logic [DATA_WIDTH-1:0]   w_rd_old;
  logic [DATA_WIDTH-1:0]   w_merged;
  logic [DATA_WIDTH-1:0]   w_rd_word;

  logic [READ_LATENCY-1:0] r_vld_p;
  logic [READ_LATENCY-1:0] r_err_p;
  logic [DATA_WIDTH-1:0]   r_dat_p [READ_LATENCY];

  assign w_wr_ok   = ({1'b0, W_ADDR} < DEPTH_L);
  assign w_rd_ok   = ({1'b0, R_ADDR} < DEPTH_L);
  assign w_collide = !W_CSb && !R_CSb && (W_ADDR == R_ADDR) && w_rd_ok;
  assign w_rd_old  = w_rd_ok ? r_mem[R_ADDR] : '0;

  // Post-write view of the read word, used only for write-through collisions
  always_comb begin
    w_merged = w_rd_old;
    for (int i = 0; i < NUM_WMASK; i++) begin
      if (W_MASK[i]) w_merged[i*LW +: LW] = W_DATA[i*LW +: LW];
    end
  end

  assign w_rd_word = (WRITE_MODE == 1 && w_collide) ? w_merged : w_rd_old;

  // Array write: array contents are deliberately untouched by reset
  always_ff @(posedge clk) begin
    if (rstb && !W_CSb && w_wr_ok) begin
      for (int i = 0; i < NUM_WMASK; i++) begin
        if (W_MASK[i]) r_mem[W_ADDR][i*LW +: LW] <= W_DATA[i*LW +: LW];
      end
    end
  end

  // Stage 0 captures the word on the accept edge; later stages only delay it
  always_ff @(posedge clk) begin
    r_dat_p[0] <= w_rd_word;
    r_err_p[0] <= !w_rd_ok;
    for (int k = 1; k < READ_LATENCY; k++) begin
      r_dat_p[k] <= r_dat_p[k-1];
      r_err_p[k] <= r_err_p[k-1];
    end
  end

  // Control and output stage: valid bits flush on reset, R_DATA/R_ERR hold between results
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      r_vld_p    <= '0;
      R_VALID    <= 1'b0;
      R_DATA     <= '0;
      R_ERR      <= 1'b0;
      COLLISIONS <= '0;
    end else begin
      r_vld_p[0] <= !R_CSb;
      for (int k = 1; k < READ_LATENCY; k++) begin
        r_vld_p[k] <= r_vld_p[k-1];
      end
      R_VALID <= r_vld_p[READ_LATENCY-1];
      if (r_vld_p[READ_LATENCY-1]) begin
        R_DATA <= r_dat_p[READ_LATENCY-1];
        R_ERR  <= r_err_p[READ_LATENCY-1];
      end
      if (w_collide && COLLISIONS != 16'hFFFF) COLLISIONS <= COLLISIONS + 16'd1;
    end
  end

endmodule
